// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the MIPS pipeline. This stage does four things:
//   - It owns the program counter.
//   - It drives the word address into the instruction ROM.
//   - It registers the returned word into the IF/ID pipeline register.
//   - It selects the next PC from sequential flow, an ID-stage jump or an
//     EX-stage taken branch.
//
//   Next-PC priority: reset > branch_taken > jump > stall > sequential.
//   A redirect squashes IF/ID to a nop. A stall holds pc and IF/ID.
//
// Parameters
//   ADDR_W    word-address width of the instruction ROM
//   RESET_PC  byte address loaded into pc on reset
//
// Ports
//   clk, reset       clock and synchronous active-high reset
//   stall            hold pc and IF/ID (load-use hazard)
//   branch_taken     EX-stage branch resolved taken, target in branch_target
//   jump             ID-stage j instruction, instr_index in jump_target
//   iram_addr        combinational word address pc[ADDR_W+1:2] to ROM
//   iram_data        combinational ROM word for iram_addr
//   pc               current fetch byte address
//   if_id_instr      registered instruction
//   if_id_pc_plus4   registered pc+4 of that instruction
//   if_id_valid      IF/ID holds a live instruction
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   Adds fetch_count (valid words loaded into IF/ID) and stall_count
//   (cycles held by stall with no redirect). Both counters are 32-bit
//   and wrap.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [31:0]       iram_data,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus4,
  output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4_s;
  logic        load_seq_s;
  logic        stall_hold_s;

  // Branch targets are word aligned by construction; the low bits carry no meaning.
  logic        unused_target_bits_s;
  assign unused_target_bits_s = ^branch_target[1:0];

  assign pc_plus4_s     = pc_q + 32'd4;
  assign iram_addr      = pc_q[ADDR_W+1:2];
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;

  // Next-PC selection and IF/ID load/squash/hold decision.
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    pp4_d        = pp4_q;
    valid_d      = valid_q;
    load_seq_s   = 1'b0;
    stall_hold_s = 1'b0;
    if (branch_taken) begin
      // Older instruction in EX wins over a jump in ID and over stall.
      pc_d    = {branch_target[31:2], 2'b00};
      instr_d = 32'h0000_0000;
      pp4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (jump) begin
      pc_d    = {pc_plus4_s[31:28], jump_target, 2'b00};
      instr_d = 32'h0000_0000;
      pp4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (stall) begin
      stall_hold_s = 1'b1;
    end else begin
      pc_d       = pc_plus4_s;
      instr_d    = iram_data;
      pp4_d      = pc_plus4_s;
      valid_d    = 1'b1;
      load_seq_s = 1'b1;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pp4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Performance counter increments.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (load_seq_s) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (stall_hold_s) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  // Without counters the decode flags only feed nothing; keep them visibly unused.
  logic unused_perf_flags_s;
  assign unused_perf_flags_s = load_seq_s ^ stall_hold_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios with literal expectations, then randomized redirects,
//   stalls and resets. A behavioural model of pc and IF/ID is compared every
//   cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_target;
  logic [5:0]  iram_addr;
  logic [31:0] iram_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [64];
  assign iram_data = rom[iram_addr];

  fetch_stage #(.ADDR_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .iram_addr      (iram_addr),
    .iram_data      (iram_data),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural pc plus the IF/ID contents.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;
  logic        m_ok = 1'b0;
  logic [31:0] m_fetch, m_stall;

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_pp4 <= 32'h0; m_valid <= 1'b0;
      m_fetch <= 32'h0; m_stall <= 32'h0; m_ok <= 1'b1;
    end else if (m_ok) begin
      if (branch_taken || jump) begin
        if (branch_taken) m_pc <= branch_target & 32'hFFFF_FFFC;
        else              m_pc <= ((m_pc + 32'd4) & 32'hF000_0000) | ({6'h0, jump_target} * 32'd4);
        m_instr <= 32'h0; m_pp4 <= 32'h0; m_valid <= 1'b0;
      end else if (stall) begin
        m_stall <= m_stall + 32'd1;
      end else begin
        m_pc    <= m_pc + 32'd4;
        m_instr <= rom[(m_pc / 32'd4) % 32'd64];
        m_pp4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_fetch <= m_fetch + 32'd1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      check("pc", pc, m_pc);
      check("iram_addr", {26'h0, iram_addr}, (m_pc / 32'd4) % 32'd64);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
      check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count, m_fetch);
      check("stall_count", stall_count, m_stall);
`endif
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'h2002_0005;
    rom[1]  = 32'h2007_0003;
    rom[2]  = 32'h2003_000c;
    rom[3]  = 32'h00e2_2025;
    rom[15] = 32'hac47_0047;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 26'h0;

    // 1: reset two cycles, then first fetch
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("t1 pc", pc, 32'h0);
    check("t1 iram_addr", {26'h0, iram_addr}, 32'h0);
    check("t1 valid", {31'h0, if_id_valid}, 32'h0);
    @(negedge clk);
    check("t1 instr", if_id_instr, 32'h2002_0005);
    check("t1 pp4", if_id_pc_plus4, 32'h4);
    check("t1 valid1", {31'h0, if_id_valid}, 32'h1);
    check("t1 pc4", pc, 32'h4);
    @(negedge clk);
    check("t2 instr1", if_id_instr, 32'h2007_0003);
    check("t2 pc8", pc, 32'h8);

    // 3: stall three cycles at pc=8
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    check("t3 pc", pc, 32'h8);
    check("t3 instr", if_id_instr, 32'h2007_0003);
    check("t3 pp4", if_id_pc_plus4, 32'h8);
    check("t3 valid", {31'h0, if_id_valid}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("t3 stall_count", stall_count, 32'd3);
`endif
    @(negedge clk);
    check("t2 instr2", if_id_instr, 32'h2003_000c);
    @(negedge clk);
    check("t2 instr3", if_id_instr, 32'h00e2_2025);
    check("t2 pc16", pc, 32'h10);

    // 4: get to pc=0x34 (low target bits ignored), then jump
    branch_taken = 1'b1; branch_target = 32'h0000_0037;
    @(negedge clk);
    branch_taken = 1'b0;
    check("t4 pc34", pc, 32'h34);
    check("t4 squash", {31'h0, if_id_valid}, 32'h0);
    jump = 1'b1; jump_target = 26'h0f;
    @(negedge clk);
    jump = 1'b0;
    check("t4 pc3c", pc, 32'h3C);
    check("t4 iram_addr", {26'h0, iram_addr}, 32'd15);
    check("t4 valid", {31'h0, if_id_valid}, 32'h0);
    @(negedge clk);
    check("t4 instr", if_id_instr, 32'hac47_0047);
    check("t4 pp4", if_id_pc_plus4, 32'h40);

    // 5: branch + jump + stall together, branch wins
    branch_taken = 1'b1; branch_target = 32'h2C; jump = 1'b1; jump_target = 26'h3; stall = 1'b1;
    @(negedge clk);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    check("t5 pc", pc, 32'h2C);
    check("t5 valid", {31'h0, if_id_valid}, 32'h0);
    check("t5 instr", if_id_instr, 32'h0);

    // 6: wrap of iram_addr past 0xFC, then reset with stall
    branch_taken = 1'b1; branch_target = 32'hFC;
    @(negedge clk);
    branch_taken = 1'b0;
    check("t6 pcfc", pc, 32'hFC);
    @(negedge clk);
    check("t6 pc100", pc, 32'h100);
    check("t6 iram_addr", {26'h0, iram_addr}, 32'h0);
    check("t6 pp4", if_id_pc_plus4, 32'h100);
    check("t6 instr", if_id_instr, rom[63]);
    reset = 1'b1; stall = 1'b1; jump = 1'b1; jump_target = 26'h3ff_ffff;
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; jump = 1'b0;
    check("t6 reset pc", pc, 32'h0);
    check("t6 reset valid", {31'h0, if_id_valid}, 32'h0);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 79) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 1) == 0) ? $urandom : {24'h0, 8'($urandom)};
      jump_target   = 26'($urandom);
      @(negedge clk);
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
